debug_controller: RTL and testbench
===================================

# debug_controller

Parametrised UART-driven debug controller sitting between the UART and the MIPS pipeline. It decodes host command bytes and gates the pipeline with a one-cycle step enable. Run modes are reset, single-step, run-to-end and run-to-breakpoint. After every stop it latches a parametrised-width pipeline snapshot and streams it to the host as a framed byte sequence. It replaces the fixed-width receive and transmit debuggers with one block and a single clock domain; the pipeline is clock-enabled, not clocked by a derived clock.

## Interface

Parameters:
- SNAP_BYTES, 176: snapshot width in bytes.
- CNT_BYTES, 4: cycle-counter width in bytes.
- PC_W, 10: PC width; must be ≤ 16.
- MAX_CYCLES, 2**20: run-mode cycle limit; must be ≤ 2**(8*CNT_BYTES)-1.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- rx_data  in  8  received UART byte.
- rx_ready  in  1  UART byte available.
- rd_uart  out  1  one-cycle pop of the received byte.
- tx_data  out  8  byte to transmit.
- tx_start  out  1  one-cycle transmit request.
- tx_busy  in  1  UART transmitter busy.
- snapshot  in  8*SNAP_BYTES  packed pipeline state; MSB byte is sent first.
- pc  in  PC_W  pipeline fetch PC.
- program_end  in  1  end-of-program detected.
- pipe_step  out  1  pipeline clock enable for one cycle.
- pipe_reset  out  1  active-high synchronous reset to the pipeline.
- cycle_count  out  8*CNT_BYTES  number of steps taken since the last pipe_reset.
- state  out  3  current FSM state encoding, for debug LEDs.
- dump_done  out  1  one-cycle pulse after the last byte of a frame has been accepted.

## Operation

- **Reset values** (reset=0 on a clock edge):
  - state=IDLE (0).
  - rd_uart, tx_start, pipe_step and dump_done are 0.
  - pipe_reset=1 for the reset cycle, then 0.
  - cycle_count=0, tx_data=0, breakpoint register=0.
  - Any frame in progress is abandoned, with no partial completion.
- **States**: IDLE(0), BP_HI(1), BP_LO(2), RUN(3), STEP(4), LOAD(5), SEND(6), WAIT(7).
- **Receive handshake**: in IDLE, BP_HI and BP_LO, when rx_ready=1:
  - rd_uart pulses for one cycle and rx_data is consumed in that cycle.
  - rx_ready is ignored in the following cycle, to allow the UART to clear it.
- **Commands in IDLE**:
  - 0x72 'r': pipe_reset=1 for one cycle, cycle_count←0, stay in IDLE.
  - 0x73 's': go to STEP.
  - 0x63 'c': clear break mode, go to RUN.
  - 0x62 'b': go to BP_HI. The next byte sets bp[15:8] and moves to BP_LO. The byte after that sets bp[7:0], enables break mode and moves to RUN. Only bp[PC_W-1:0] is compared.
  - 0x64 'd': go to LOAD.
  - Any other byte: consumed and ignored.
- **STEP**:
  - If program_end=1: no step.
  - Otherwise pipe_step=1 for exactly one cycle and cycle_count increments.
  - Next state is LOAD.
- **RUN**, each cycle, checked in priority order:
  1. Abort: rx_ready=1 with rx_data=0x78 'x'. The byte is popped and the FSM goes to LOAD. Other bytes arriving in RUN are popped and discarded.
  2. Stop condition: program_end=1, or cycle_count==MAX_CYCLES, or break mode with pc==bp. The FSM goes to LOAD with no step in that cycle.
  3. Otherwise pipe_step=1 and cycle_count+1.
- **Breakpoint re-entry**: the break test is suppressed on the first RUN cycle, so a 'b' at the current PC advances.
- **cycle_count**: saturates at its all-ones value. It never wraps.
- **LOAD** (one cycle):
  - Latch snapshot and cycle_count into the frame shift register.
  - Byte index←0, go to SEND.
- **Frame format**, total CNT_BYTES+SNAP_BYTES+1 bytes:
  1. Header 0xA5.
  2. cycle_count, MSB byte first.
  3. Snapshot, MSB byte first.
- **SEND**: when tx_busy=0, drive tx_data with the current byte, pulse tx_start for one cycle, go to WAIT.
- **WAIT**:
  - tx_busy is ignored in the first cycle.
  - From the second cycle, once tx_busy=0, advance the index.
  - If more bytes remain, go to SEND. Otherwise pulse dump_done and go to IDLE.
- **Frame contents are frozen**: pipe_step stays 0 throughout LOAD, SEND and WAIT, so later pipeline activity does not affect the frame.

## Timing

- **Command to step**:
  - 's': rd_uart at cycle T, STEP at T+1, pipe_step at T+1, LOAD at T+2, first tx_start at T+3 (tx_busy=0).
  - 'c': first pipe_step at T+1.
- **Stop to dump**: the stop condition is sampled in cycle N, LOAD follows at N+1, and the header tx_start comes at N+2.
- **Transmit rules**:
  - The UART must raise tx_busy within one cycle of tx_start.
  - Consecutive tx_start pulses are at least 3 cycles apart.
  - tx_data is held stable from tx_start until WAIT exits.
- **Simultaneous events in RUN**: an abort byte and a stop condition in the same cycle produce a single LOAD, and the abort byte is still popped.
- **Pipeline reset timing**: pipe_reset and pipe_step are never high in the same cycle. cycle_count reads 0 in the cycle after pipe_reset.
- **Reset mid-frame**: tx_start goes low the next cycle. The UART finishes the byte it has already started.

## Test plan

Bench parameters: SNAP_BYTES=4, CNT_BYTES=2, PC_W=10, MAX_CYCLES=100.

- **Reset then 'r'**: reset=0 for 2 cycles, then send 0x72 → all outputs take their reset values, pipe_reset pulses once, cycle_count=0.
- **Single step**: snapshot=0xDEADBEEF, send 's' → exactly 1 pipe_step. Frame is A5 00 01 DE AD BE EF, then dump_done.
- **Run to end**: 'c', with program_end raised after 37 steps → exactly 37 pipe_step pulses. Frame count bytes are 00 25.
- **Cycle limit**: 'c' with program_end held at 0 → stops at cycle_count=100 (00 64). A second 'c' stops immediately with 0 further steps.
- **Breakpoint**: 'b' 0x01 0x0C with the pc model incrementing by 4 from 0x100 → stops when pc=0x10C after 3 steps. Re-issuing the same 'b' advances at least 1 step.
- **Abort and reset mid-frame**: send 'x' at RUN cycle 10 → LOAD at the next cycle, count bytes 00 0A. Assert reset during byte 3 of that frame → no further tx_start, state=IDLE, dump_done never pulses.

Source files
------------

// File: rtl/debug_controller.sv
// UART-driven debug controller: decodes host commands, gates the pipeline with a
// one-cycle step enable and streams a framed cycle-count + snapshot dump after each stop.
module debug_controller #(
   parameter int SNAP_BYTES = 176,
   parameter int CNT_BYTES  = 4,
   parameter int PC_W       = 10,
   parameter int MAX_CYCLES = 2**20
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [7:0]                rx_data,
   input  logic                      rx_ready,
   output logic                      rd_uart,
   output logic [7:0]                tx_data,
   output logic                      tx_start,
   input  logic                      tx_busy,
   input  logic [8*SNAP_BYTES-1:0]   snapshot,
   input  logic [PC_W-1:0]           pc,
   input  logic                      program_end,
   output logic                      pipe_step,
   output logic                      pipe_reset,
   output logic [8*CNT_BYTES-1:0]    cycle_count,
   output logic [2:0]                state,
   output logic                      dump_done
);

   localparam int CNT_W       = 8*CNT_BYTES;
   localparam int FRAME_BYTES = CNT_BYTES + SNAP_BYTES + 1;
   localparam int FRAME_W     = 8*FRAME_BYTES;
   localparam int IDX_W       = $clog2(FRAME_BYTES + 1);

   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_CYCLES);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_BYTES - 1);
   localparam logic [15:0]      BP_MASK   = 16'((32'd1 << PC_W) - 32'd1);

   localparam logic [7:0] CMD_RESET = 8'h72;
   localparam logic [7:0] CMD_STEP  = 8'h73;
   localparam logic [7:0] CMD_CONT  = 8'h63;
   localparam logic [7:0] CMD_BREAK = 8'h62;
   localparam logic [7:0] CMD_DUMP  = 8'h64;
   localparam logic [7:0] CMD_ABORT = 8'h78;
   localparam logic [7:0] HEADER    = 8'hA5;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      BP_HI = 3'd1,
      BP_LO = 3'd2,
      RUN   = 3'd3,
      STEP  = 3'd4,
      LOAD  = 3'd5,
      SEND  = 3'd6,
      WAIT  = 3'd7
   } state_t;

   state_t               state_q, state_d;
   logic                 rx_hold;
   logic                 first_run;
   logic [15:0]          bp;
   logic                 break_mode;
   logic [CNT_W-1:0]     cnt_q;
   logic [FRAME_W-1:0]   frame_sr;
   logic [IDX_W-1:0]     byte_idx;
   logic                 wait_first;

   logic rx_pop, bp_match, stop_cond, abort, wait_done, last_byte;

   // rx_hold masks rx_ready for the cycle after a pop while the UART clears it
   assign rx_pop    = rx_ready && !rx_hold;
   assign bp_match  = (bp & BP_MASK) == 16'(pc);
   assign stop_cond = program_end || (cnt_q == CNT_LIMIT) ||
                      (break_mode && !first_run && bp_match);
   assign abort     = rx_pop && (rx_data == CMD_ABORT);
   assign wait_done = (state_q == WAIT) && !wait_first && !tx_busy;
   assign last_byte = (byte_idx == LAST_IDX);

   assign state       = state_q;
   assign cycle_count = cnt_q;
   assign tx_data     = frame_sr[FRAME_W-1 -: 8];

   always_ff @(posedge clock) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (rx_pop) begin
               case (rx_data)
                  CMD_STEP:  state_d = STEP;
                  CMD_CONT:  state_d = RUN;
                  CMD_BREAK: state_d = BP_HI;
                  CMD_DUMP:  state_d = LOAD;
                  default:   state_d = IDLE;
               endcase
            end
         end
         BP_HI:   if (rx_pop) state_d = BP_LO;
         BP_LO:   if (rx_pop) state_d = RUN;
         RUN:     if (abort || stop_cond) state_d = LOAD;
         STEP:    state_d = LOAD;
         LOAD:    state_d = SEND;
         SEND:    if (!tx_busy) state_d = WAIT;
         WAIT:    if (wait_done) state_d = last_byte ? IDLE : SEND;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_uart    = 1'b0;
      tx_start   = 1'b0;
      pipe_step  = 1'b0;
      pipe_reset = 1'b0;
      dump_done  = 1'b0;
      if (!reset) begin
         pipe_reset = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               rd_uart    = rx_pop;
               pipe_reset = rx_pop && (rx_data == CMD_RESET);
            end
            BP_HI, BP_LO: rd_uart = rx_pop;
            RUN: begin
               rd_uart   = rx_pop;
               pipe_step = !(abort || stop_cond);
            end
            STEP:    pipe_step = !program_end;
            SEND:    tx_start  = !tx_busy;
            WAIT:    dump_done = wait_done && last_byte;
            default: ;
         endcase
      end
   end

   // Datapath: counter, breakpoint, and the frame shift register whose top byte is tx_data
   always_ff @(posedge clock) begin
      if (!reset) begin
         rx_hold    <= 1'b0;
         first_run  <= 1'b1;
         bp         <= '0;
         break_mode <= 1'b0;
         cnt_q      <= '0;
         frame_sr   <= '0;
         byte_idx   <= '0;
         wait_first <= 1'b0;
      end else begin
         rx_hold    <= rd_uart;
         first_run  <= (state_q != RUN);
         wait_first <= (state_q == SEND);

         if (pipe_reset)
            cnt_q <= '0;
         else if (pipe_step && (cnt_q != '1))
            cnt_q <= cnt_q + CNT_W'(1);

         if ((state_q == IDLE) && rx_pop && (rx_data == CMD_CONT))
            break_mode <= 1'b0;
         if ((state_q == BP_HI) && rx_pop)
            bp[15:8] <= rx_data;
         if ((state_q == BP_LO) && rx_pop) begin
            bp[7:0]    <= rx_data;
            break_mode <= 1'b1;
         end

         if (state_q == LOAD) begin
            frame_sr <= {HEADER, cnt_q, snapshot};
            byte_idx <= '0;
         end else if (wait_done) begin
            frame_sr <= {frame_sr[FRAME_W-9:0], 8'h00};
            if (!last_byte)
               byte_idx <= byte_idx + IDX_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_debug_controller.sv
// Directed bench for debug_controller: table of command scenarios with expected frames,
// plus hand-written reset, timing, abort and mid-frame reset sequences.
module tb_debug_controller;

   localparam int SNAP_BYTES = 4;
   localparam int CNT_BYTES  = 2;
   localparam int PC_W       = 10;
   localparam int MAX_CYCLES = 100;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_ready = 1'b0;
   logic              rd_uart;
   logic [7:0]        tx_data;
   logic              tx_start;
   logic              tx_busy;
   logic [31:0]       snapshot = 32'h0;
   logic [PC_W-1:0]   pc;
   logic              program_end;
   logic              pipe_step;
   logic              pipe_reset;
   logic [15:0]       cycle_count;
   logic [2:0]        state;
   logic              dump_done;

   debug_controller #(
      .SNAP_BYTES(SNAP_BYTES),
      .CNT_BYTES (CNT_BYTES),
      .PC_W      (PC_W),
      .MAX_CYCLES(MAX_CYCLES)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .rd_uart    (rd_uart),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .tx_busy    (tx_busy),
      .snapshot   (snapshot),
      .pc         (pc),
      .program_end(program_end),
      .pipe_step  (pipe_step),
      .pipe_reset (pipe_reset),
      .cycle_count(cycle_count),
      .state      (state),
      .dump_done  (dump_done)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Pipeline and UART models: outputs sampled mid-cycle, state advanced on the edge
   int  model_steps = 0;
   int  end_at      = 1000;
   int  busy_cnt    = 0;
   int  cyc         = 0;
   bit  step_seen   = 0;
   bit  prst_seen   = 0;
   bit  start_seen  = 0;

   assign tx_busy     = (busy_cnt != 0);
   assign pc          = PC_W'(32'h100 + 4*model_steps);
   assign program_end = (model_steps >= end_at);

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (prst_seen)      model_steps <= 0;
      else if (step_seen) model_steps <= model_steps + 1;
      if (start_seen)        busy_cnt <= 3;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end

   logic [7:0] tx_q[$];
   int dump_cnt = 0, prst_cnt = 0, step_cnt = 0, overlap_cnt = 0;
   int last_rd_cyc = 0, first_step_cyc = -1, first_tx_cyc = -1;

   always @(negedge clock) begin
      step_seen  = pipe_step;
      prst_seen  = pipe_reset;
      start_seen = tx_start;
      if (rd_uart) begin
         last_rd_cyc    = cyc;
         first_step_cyc = -1;
         first_tx_cyc   = -1;
      end
      if (pipe_step) begin
         step_cnt++;
         if (first_step_cyc < 0) first_step_cyc = cyc;
      end
      if (tx_start) begin
         tx_q.push_back(tx_data);
         if (first_tx_cyc < 0) first_tx_cyc = cyc;
      end
      if (dump_done) dump_cnt++;
      if (pipe_reset) prst_cnt++;
      if (pipe_reset && pipe_step) overlap_cnt++;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit got;
      got = 0;
      @(posedge clock);
      #1;
      rx_data  = b;
      rx_ready = 1'b1;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clock);
         if (rd_uart) got = 1;
      end
      @(posedge clock);
      #1;
      rx_ready = 1'b0;
      checkOutput($sformatf("rx_pop_%02h", b), 64'(got), 64'd1);
   endtask

   typedef struct {
      bit          do_r;
      logic [7:0]  b0, b1, b2;
      int          nb;
      int          end_at;
      logic [31:0] snap;
      int          exp_steps;
      logic [15:0] exp_cnt;
      bit          chk_timing;
   } vec_t;

   task automatic applyStimulus(input vec_t v, input int idx);
      int base, s0, d0, p0;
      logic [55:0] got_frame;
      if (v.do_r) begin
         p0 = prst_cnt;
         send_byte(8'h72);
         checkOutput($sformatf("v%0d_prst_pulses", idx), 64'(prst_cnt - p0), 64'd1);
         checkOutput($sformatf("v%0d_cnt_cleared", idx), 64'(cycle_count), 64'd0);
      end
      end_at   = v.end_at;
      snapshot = v.snap;
      base     = tx_q.size();
      s0       = step_cnt;
      d0       = dump_cnt;
      send_byte(v.b0);
      if (v.nb > 1) send_byte(v.b1);
      if (v.nb > 2) send_byte(v.b2);
      for (int i = 0; i < 3000 && dump_cnt == d0; i++) begin
         @(posedge clock);
         #1;
         if (tx_q.size() > base) snapshot = ~v.snap;
      end
      checkOutput($sformatf("v%0d_dump_done", idx), 64'(dump_cnt - d0), 64'd1);
      checkOutput($sformatf("v%0d_steps", idx), 64'(step_cnt - s0), 64'(v.exp_steps));
      checkOutput($sformatf("v%0d_frame_len", idx), 64'(tx_q.size() - base), 64'd7);
      got_frame = '0;
      if (tx_q.size() >= base + 7)
         for (int k = 0; k < 7; k++) got_frame = {got_frame[47:0], tx_q[base + k]};
      checkOutput($sformatf("v%0d_frame", idx), 64'(got_frame), 64'({8'hA5, v.exp_cnt, v.snap}));
      @(negedge clock);
      checkOutput($sformatf("v%0d_idle", idx), 64'(state), 64'd0);
      if (v.chk_timing) begin
         checkOutput($sformatf("v%0d_step_lat", idx), 64'(first_step_cyc - last_rd_cyc), 64'd1);
         checkOutput($sformatf("v%0d_tx_lat", idx), 64'(first_tx_cyc - last_rd_cyc), 64'd3);
      end
   endtask

   vec_t vecs[9];

   initial begin
      int base, d0;
      bit reached;
      logic [23:0] head;

      vecs[0] = '{1, 8'h73, 8'h00, 8'h00, 1, 1000, 32'hDEADBEEF, 1,  16'h0001, 1};
      vecs[1] = '{1, 8'h63, 8'h00, 8'h00, 1, 37,   32'h12345678, 37, 16'h0025, 0};
      vecs[2] = '{1, 8'h63, 8'h00, 8'h00, 1, 1000, 32'hCAFEF00D, 100, 16'h0064, 0};
      vecs[3] = '{0, 8'h63, 8'h00, 8'h00, 1, 1000, 32'h0BADC0DE, 0,  16'h0064, 0};
      vecs[4] = '{1, 8'h62, 8'h01, 8'h0C, 3, 1000, 32'h01020304, 3,  16'h0003, 0};
      vecs[5] = '{0, 8'h62, 8'h01, 8'h0C, 3, 1000, 32'hA0B0C0D0, 97, 16'h0064, 0};
      vecs[6] = '{0, 8'h64, 8'h00, 8'h00, 1, 1000, 32'h55AA55AA, 0,  16'h0064, 0};
      vecs[7] = '{1, 8'h73, 8'h00, 8'h00, 1, 0,    32'h11223344, 0,  16'h0000, 0};
      vecs[8] = '{0, 8'h71, 8'h64, 8'h00, 2, 1000, 32'h99887766, 0,  16'h0000, 0};

      // Reset held for two edges, outputs checked mid-cycle
      @(negedge clock);
      checkOutput("rst_state", 64'(state), 64'd0);
      checkOutput("rst_cnt", 64'(cycle_count), 64'd0);
      checkOutput("rst_tx_data", 64'(tx_data), 64'd0);
      checkOutput("rst_pipe_reset", 64'(pipe_reset), 64'd1);
      checkOutput("rst_strobes", 64'({rd_uart, tx_start, pipe_step, dump_done}), 64'd0);
      @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      checkOutput("post_rst_pipe_reset", 64'(pipe_reset), 64'd0);

      for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

      // Abort with 'x' on the RUN cycle where ten steps have been taken
      end_at   = 1000;
      snapshot = 32'h0F1E2D3C;
      send_byte(8'h72);
      base = tx_q.size();
      d0   = dump_cnt;
      send_byte(8'h63);
      reached = 0;
      for (int i = 0; i < 200 && !reached; i++) begin
         @(posedge clock);
         #1;
         if (model_steps == 10) reached = 1;
      end
      checkOutput("abort_reach_10", 64'(reached), 64'd1);
      rx_data  = 8'h78;
      rx_ready = 1'b1;
      @(negedge clock);
      checkOutput("abort_pop", 64'(rd_uart), 64'd1);
      checkOutput("abort_no_step", 64'(pipe_step), 64'd0);
      @(posedge clock);
      #1 rx_ready = 1'b0;
      @(negedge clock);
      checkOutput("abort_load", 64'(state), 64'd5);

      reached = 0;
      for (int i = 0; i < 200 && !reached; i++) begin
         @(posedge clock);
         #1;
         if (tx_q.size() >= base + 3) reached = 1;
      end
      checkOutput("abort_three_bytes", 64'(reached), 64'd1);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("midframe_tx_start", 64'(tx_start), 64'd0);
      checkOutput("midframe_pipe_reset", 64'(pipe_reset), 64'd1);
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b1;
      repeat (30) @(posedge clock);
      @(negedge clock);
      checkOutput("midframe_tx_count", 64'(tx_q.size() - base), 64'd3);
      checkOutput("midframe_state", 64'(state), 64'd0);
      checkOutput("midframe_no_dump", 64'(dump_cnt - d0), 64'd0);
      checkOutput("midframe_cnt", 64'(cycle_count), 64'd0);
      head = '0;
      if (tx_q.size() >= base + 3) head = {tx_q[base], tx_q[base+1], tx_q[base+2]};
      checkOutput("abort_frame_head", 64'(head), 64'h00A5000A);

      checkOutput("reset_step_overlap", 64'(overlap_cnt), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "[TB] timeout");
   end

endmodule
